onchip_mem_port_arbiter: RTL and testbench
==========================================

ONCHIP_MEM_PORT_ARBITER -- requirements
Module: onchip_mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive losses after which master 1 is forced (fixed-priority mode only).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports m0_address/m1_address, input, ADDR_W, master word address.
REQ-007 SHALL have ports m0_byteenable/m1_byteenable, input, DATA_W/8, byte lanes.
REQ-008 SHALL have ports m0_read/m1_read and m0_write/m1_write, input, 1, access requests.
REQ-009 SHALL have ports m0_writedata/m1_writedata, input, DATA_W, write data.
REQ-010 SHALL have ports m0_waitrequest/m1_waitrequest, output, 1, request not accepted this cycle.
REQ-011 SHALL have ports m0_readdata/m1_readdata, output, DATA_W, read data; m0_readdatavalid/m1_readdatavalid, output, 1, read data qualifier.
REQ-012 SHALL have memory-side outputs mem_address (ADDR_W), mem_byteenable (DATA_W/8), mem_writedata (DATA_W), mem_chipselect (1), mem_write (1), mem_clken (1), and input mem_readdata (DATA_W) to one port of the dual-port on-chip RAM.

Function
REQ-013 SHALL treat master k as requesting when mk_read or mk_write is high.
REQ-014 SHALL grant at most one master per cycle, combinationally, in the same cycle the request is presented.
REQ-015 SHALL drive mem_* from the granted master with mem_chipselect=1, mem_write=mk_write; with no grant mem_chipselect=0, mem_write=0.
REQ-016 SHALL set mk_waitrequest = request_k AND NOT grant_k; a non-requesting master sees waitrequest=0.
REQ-017 SHALL, for a read granted in cycle N, assert mk_readdatavalid for exactly cycle N+1 with mk_readdata=mem_readdata (RAM address registered, output unregistered: latency 1).
REQ-018 SHALL hold a one-bit in-flight tag (valid, owner) to route read data; the non-owner's readdatavalid stays 0.
REQ-019 SHALL sustain one grant per cycle, including back-to-back reads to alternating masters.
REQ-020 SHALL, if read and write are both high on the granted master, perform the write only and issue no readdatavalid.
REQ-021 SHALL keep register last_grant (0/1), updated on every granted cycle.
REQ-022 SHALL drive mem_clken=1 whenever reset is low.
REQ-023 SHALL grant a lone requester immediately regardless of mode.

Reset
REQ-024 SHALL, while reset is high at a clk edge, clear in-flight tag, set last_grant=1, clear starve counter.
REQ-025 SHALL, while reset is high, drive m0/m1_waitrequest=1, readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0; readdata outputs are don't-care.
REQ-026 SHALL drop a read in flight when reset asserts; no readdatavalid follows reset release.

Configuration
REQ-027 SHALL, with macro ARB_ROUND_ROBIN_EN defined, grant the master NOT equal to last_grant when both request; starve counter is absent.
REQ-028 SHALL, without ARB_ROUND_ROBIN_EN, grant master 0 when both request, except: a saturating counter counts cycles master 1 requests and loses; when it equals STARVE_LIMIT master 1 is granted and the counter clears; it also clears whenever master 1 is granted or stops requesting.

Verification
REQ-029 SHALL check: m0 read addr 0x0010 alone -> m0_waitrequest=0 cycle N, m0_readdatavalid=1 cycle N+1 with RAM word 0x10.
REQ-030 SHALL check (RR): both read continuously from reset -> grants alternate m0,m1,m0,m1; each readdatavalid on own master only, one cycle after grant.
REQ-031 SHALL check (fixed): both request continuously, STARVE_LIMIT=4 -> m0 granted 4 cycles, m1 granted 5th, pattern repeats.
REQ-032 SHALL check: m1 write 0xDEADBEEF byteenable 0x3 to addr 0x1FFF, then m0 read 0x1FFF -> lower halfword 0xBEEF, upper halfword unchanged.
REQ-033 SHALL check: reset asserted in cycle after read grant -> no readdatavalid, both waitrequest=1, mem_chipselect=0 during reset; first grant after release goes to m0 when both request.
REQ-034 SHALL check: m0 read and write both high -> write performed, m0_readdatavalid stays 0.

Source files
------------

// File: rtl/onchip_mem_port_arbiter.sv
// Two-master arbiter sharing one port of a dual-port on-chip RAM (registered address, read latency 1).
// Macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority to master 0 with a starvation guard for master 1.
module onchip_mem_port_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic req0_s;
  logic req1_s;
  logic grant0_s;
  logic grant1_s;
  logic rd_issue_s;
  logic last_grant_r;
  logic inflight_valid_r;
  logic inflight_owner_r;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Contention goes to the master that did not win last time
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_s && req1_s) begin
      if (last_grant_r) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (req0_s) begin
      grant0_s = 1'b1;
    end else if (req1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_r;

  // Contention goes to master 0 unless master 1 has waited STARVE_LIMIT cycles
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_s && req1_s) begin
      if (starve_cnt_r == STARVE_MAX) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b1;
      end
    end else if (req0_s) begin
      grant0_s = 1'b1;
    end else if (req1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Saturating count of consecutive cycles master 1 requests and loses
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (!req1_s || grant1_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

  // Steer the granted master onto the RAM port
  always_comb begin
    mem_address    = {ADDR_W{1'b0}};
    mem_byteenable = {(DATA_W/8){1'b0}};
    mem_writedata  = {DATA_W{1'b0}};
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    rd_issue_s     = 1'b0;
    case ({grant1_s, grant0_s})
      2'b01: begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_chipselect = 1'b1;
        mem_write      = m0_write;
        rd_issue_s     = m0_read & ~m0_write;
      end
      2'b10: begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
        mem_chipselect = 1'b1;
        mem_write      = m1_write;
        rd_issue_s     = m1_read & ~m1_write;
      end
      default: begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        rd_issue_s     = 1'b0;
      end
    endcase
  end

  // Master-side handshake; everyone is held off while in reset
  always_comb begin
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    mem_clken        = 1'b0;
    if (reset) begin
      m0_waitrequest   = 1'b1;
      m1_waitrequest   = 1'b1;
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
      mem_clken        = 1'b0;
    end else begin
      m0_waitrequest   = req0_s & ~grant0_s;
      m1_waitrequest   = req1_s & ~grant1_s;
      m0_readdatavalid = inflight_valid_r & ~inflight_owner_r;
      m1_readdatavalid = inflight_valid_r & inflight_owner_r;
      mem_clken        = 1'b1;
    end
  end

  // RAM output is unregistered here; the valid strobes decide who may use it
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

  // Track last winner and the single read that may be in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r     <= 1'b1;
      inflight_valid_r <= 1'b0;
      inflight_owner_r <= 1'b0;
    end else begin
      if (grant0_s || grant1_s) begin
        last_grant_r <= grant1_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
      inflight_valid_r <= rd_issue_s;
      if (rd_issue_s) begin
        inflight_owner_r <= grant1_s;
      end else begin
        inflight_owner_r <= inflight_owner_r;
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Directed bench for onchip_mem_port_arbiter with a behavioural latency-1 RAM on the memory port.
module tb_onchip_mem_port_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  int check_cnt;
  int error_cnt;

  onchip_mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [12:0] a);
    return {16'hC0DE, 3'b000, a};
  endfunction

  // RAM model: registered address, byte-lane writes, one-cycle read latency
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
  endtask

  int exp_g;
  int prev_g;

  initial begin
    check_cnt = 0;
    error_cnt = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = init_word(13'(i));
    mem_readdata = 32'h0;
    m0_address = 13'h0; m1_address = 13'h0;
    m0_writedata = 32'h0; m1_writedata = 32'h0;
    idle();
    reset = 1'b1;

    // Reset: outputs forced even with requests present
    @(negedge clk);
    @(negedge clk);
    m0_read = 1'b1; m1_write = 1'b1;
    #1;
    check_val("rst_wait0", m0_waitrequest, 1'b1);
    check_val("rst_wait1", m1_waitrequest, 1'b1);
    check_val("rst_cs", mem_chipselect, 1'b0);
    check_val("rst_wr", mem_write, 1'b0);
    check_val("rst_clken", mem_clken, 1'b0);
    check_val("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);

    @(negedge clk);
    reset = 1'b0; idle();
    #1;
    check_val("rel_clken", mem_clken, 1'b1);
    check_val("rel_cs", mem_chipselect, 1'b0);
    check_val("rel_wait", {m0_waitrequest, m1_waitrequest}, 2'b00);

    // Both masters read continuously from reset
    m0_address = 13'h040; m1_address = 13'h041;
    prev_g = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m0_read = 1'b1; m1_read = 1'b1;
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = i % 2;
`else
      exp_g = ((i % 5) == 4) ? 1 : 0;
`endif
      check_val("arb_wait0", m0_waitrequest, (exp_g != 0));
      check_val("arb_wait1", m1_waitrequest, (exp_g != 1));
      check_val("arb_addr", mem_address, (exp_g == 1) ? 13'h041 : 13'h040);
      if (prev_g >= 0) begin
        check_val("arb_rdv0", m0_readdatavalid, (prev_g == 0));
        check_val("arb_rdv1", m1_readdatavalid, (prev_g == 1));
        check_val("arb_data", (prev_g == 1) ? m1_readdata : m0_readdata,
                  init_word((prev_g == 1) ? 13'h041 : 13'h040));
      end
      prev_g = exp_g;
    end
    @(negedge clk);
    idle();
    #1;
    check_val("arb_last_rdv", {m1_readdatavalid, m0_readdatavalid}, (prev_g == 1) ? 2'b10 : 2'b01);

    // Lone m0 read of 0x0010
    @(negedge clk);
    m0_read = 1'b1; m0_address = 13'h0010;
    #1;
    check_val("rd_wait0", m0_waitrequest, 1'b0);
    check_val("rd_cs", mem_chipselect, 1'b1);
    check_val("rd_wr", mem_write, 1'b0);
    check_val("rd_addr", mem_address, 13'h0010);
    @(negedge clk);
    idle();
    #1;
    check_val("rd_rdv0", m0_readdatavalid, 1'b1);
    check_val("rd_rdv1", m1_readdatavalid, 1'b0);
    check_val("rd_data", m0_readdata, 32'hC0DE0010);
    @(negedge clk);
    #1;
    check_val("rd_rdv0_once", m0_readdatavalid, 1'b0);

    // m1 partial write at top address, m0 reads it back
    @(negedge clk);
    m1_write = 1'b1; m1_address = 13'h1FFF; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'h3;
    #1;
    check_val("wr_wait1", m1_waitrequest, 1'b0);
    check_val("wr_memwr", mem_write, 1'b1);
    check_val("wr_be", mem_byteenable, 4'h3);
    check_val("wr_data", mem_writedata, 32'hDEADBEEF);
    @(negedge clk);
    idle();
    m0_read = 1'b1; m0_address = 13'h1FFF;
    #1;
    check_val("wr_rdv1", m1_readdatavalid, 1'b0);
    check_val("wr_rd_wait0", m0_waitrequest, 1'b0);
    @(negedge clk);
    idle();
    #1;
    check_val("wr_rb_rdv0", m0_readdatavalid, 1'b1);
    check_val("wr_rb_data", m0_readdata, 32'hC0DEBEEF);

    // m0 read and write together: write only
    @(negedge clk);
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 13'h0020; m0_writedata = 32'h12345678;
    #1;
    check_val("rw_memwr", mem_write, 1'b1);
    check_val("rw_wait0", m0_waitrequest, 1'b0);
    @(negedge clk);
    idle();
    m0_read = 1'b1;
    #1;
    check_val("rw_no_rdv", m0_readdatavalid, 1'b0);
    @(negedge clk);
    idle();
    #1;
    check_val("rw_rb_data", m0_readdata, 32'h12345678);
    check_val("rw_rb_rdv", m0_readdatavalid, 1'b1);

    // Reset in the cycle after a read grant drops the read
    @(negedge clk);
    m0_read = 1'b1; m0_address = 13'h0010;
    #1;
    check_val("rf_wait0", m0_waitrequest, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; m0_read = 1'b1; m1_read = 1'b1;
      #1;
      check_val("rf_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
      check_val("rf_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
      check_val("rf_cs", mem_chipselect, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0; idle();
    #1;
    check_val("rf_rel_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    @(negedge clk);
    m0_read = 1'b1; m1_read = 1'b1; m1_address = 13'h0011;
    #1;
    check_val("rf_first_wait0", m0_waitrequest, 1'b0);
    check_val("rf_first_wait1", m1_waitrequest, 1'b1);
    @(negedge clk);
    idle();
    #1;
    check_val("rf_first_rdv0", m0_readdatavalid, 1'b1);
    check_val("rf_first_data", m0_readdata, 32'hC0DE0010);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
